// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM fade scheduler.
package pwm_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_RW    = 4;

    typedef logic [DEF_WIDTH-1:0] duty_t;
    typedef logic [DEF_RW-1:0]    rate_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } sched_state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// One fade step for a single busy channel: rate prescale, then one LSB toward target.
module pwm_ramp_step
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RW    = DEF_RW
) (
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] target,
    input  logic [RW-1:0]    rate,
    input  logic [RW-1:0]    rate_cnt,
    output logic [WIDTH-1:0] duty_next,
    output logic [RW-1:0]    rate_cnt_next,
    output logic             reached
);

    // Either burn one prescale frame or move duty; the target bounds the move so duty never wraps.
    always_comb begin
        duty_next     = duty;
        rate_cnt_next = rate_cnt;
        reached       = 1'b0;
        if (rate_cnt < rate) begin
            rate_cnt_next = rate_cnt + RW'(1);
        end else begin
            rate_cnt_next = '0;
            if (duty < target) begin
                duty_next = duty + WIDTH'(1);
            end else if (duty > target) begin
                duty_next = duty - WIDTH'(1);
            end
            reached = (duty_next == target);
        end
    end

endmodule

// File: rtl/pwm_fade_sched.sv
// Multi-channel duty fade scheduler: command write path, per-channel register file
// and a frame walker that steps one channel per cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepting commands; frame_tick starts a walk at channel 0
//   WALK  | stepping channel walk_idx; commands blocked; ends after NCH-1
module pwm_fade_sched
    import pwm_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int RW    = DEF_RW
) (
    input  logic                    mclk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(NCH)-1:0]  req_ch,
    input  logic [WIDTH-1:0]        req_target,
    input  logic [RW-1:0]           req_rate,
    output logic [NCH*WIDTH-1:0]    duty,
    output logic [NCH-1:0]          busy,
    output logic                    done,
    output logic [$clog2(NCH)-1:0]  done_ch
);

    localparam int CW = $clog2(NCH);
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    sched_state_t     state, state_next;
    logic [CW-1:0]    walk_idx, walk_idx_next;

    logic [WIDTH-1:0] duty_q   [NCH];
    logic [WIDTH-1:0] target_q [NCH];
    logic [RW-1:0]    rate_q   [NCH];
    logic [RW-1:0]    rcnt_q   [NCH];
    logic [NCH-1:0]   busy_q;
    logic             done_q;
    logic [CW-1:0]    done_ch_q;

    logic             accept;
    logic [WIDTH-1:0] step_duty;
    logic [RW-1:0]    step_rcnt;
    logic             step_reached;

    // State register and walk index.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state    <= IDLE;
            walk_idx <= '0;
        end else begin
            state    <= state_next;
            walk_idx <= walk_idx_next;
        end
    end

    // Next-state logic; ready is held low during reset so nothing is accepted then.
    always_comb begin
        state_next    = state;
        walk_idx_next = '0;
        req_ready     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (frame_tick) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                if (walk_idx == LAST_CH) begin
                    state_next = IDLE;
                end else begin
                    walk_idx_next = walk_idx + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    pwm_ramp_step #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_step (
        .duty          (duty_q[walk_idx]),
        .target        (target_q[walk_idx]),
        .rate          (rate_q[walk_idx]),
        .rate_cnt      (rcnt_q[walk_idx]),
        .duty_next     (step_duty),
        .rate_cnt_next (step_rcnt),
        .reached       (step_reached)
    );

    // Register file: commands only land in IDLE, the walker only runs in WALK, so they never collide.
    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= '0;
                target_q[i] <= '0;
                rate_q[i]   <= '0;
                rcnt_q[i]   <= '0;
            end
            busy_q    <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == WALK) begin
                if (busy_q[walk_idx]) begin
                    duty_q[walk_idx] <= step_duty;
                    rcnt_q[walk_idx] <= step_rcnt;
                    if (step_reached) begin
                        busy_q[walk_idx] <= 1'b0;
                        done_q           <= 1'b1;
                        done_ch_q        <= walk_idx;
                    end
                end
            end else if (accept) begin
                target_q[req_ch] <= req_target;
                rate_q[req_ch]   <= req_rate;
                rcnt_q[req_ch]   <= '0;
                busy_q[req_ch]   <= (req_target != duty_q[req_ch]);
            end
        end
    end

    // Flatten per-channel duty onto the PWM threshold bus.
    always_comb begin
        duty = '0;
        for (int i = 0; i < NCH; i++) begin
            duty[i*WIDTH +: WIDTH] = duty_q[i];
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign done_ch = done_ch_q;

endmodule

// File: tb/tb_pwm_fade_sched.sv
// Directed bench for pwm_fade_sched with NCH=4, WIDTH=8, RW=4.
module tb_pwm_fade_sched;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int RW    = 4;

    logic                 mclk = 1'b0;
    logic                 rst;
    logic                 frame_tick;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_ch;
    logic [WIDTH-1:0]     req_target;
    logic [RW-1:0]        req_rate;
    logic [NCH*WIDTH-1:0] duty;
    logic [NCH-1:0]       busy;
    logic                 done;
    logic [1:0]           done_ch;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen;
    int last_done_ch;
    int last_done_pos;

    pwm_fade_sched #(.NCH(NCH), .WIDTH(WIDTH), .RW(RW)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ch     (req_ch),
        .req_target (req_target),
        .req_rate   (req_rate),
        .duty       (duty),
        .busy       (busy),
        .done       (done),
        .done_ch    (done_ch)
    );

    always #5 mclk = ~mclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] duty_of(input int ch);
        return duty[ch*WIDTH +: WIDTH];
    endfunction

    task automatic send_cmd(input int ch, input int tgt, input int rate);
        int n = 0;
        req_valid  = 1'b1;
        req_ch     = 2'(ch);
        req_target = WIDTH'(tgt);
        req_rate   = RW'(rate);
        #1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // One frame: tick in IDLE, then the NCH walk cycles; position j sees channel j's step result.
    task automatic run_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            tick();
            if (done) begin
                done_seen++;
                last_done_ch  = int'(done_ch);
                last_done_pos = j;
            end
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    initial begin
        int lows;
        rst        = 1'b1;
        frame_tick = 1'b0;
        req_valid  = 1'b0;
        req_ch     = '0;
        req_target = '0;
        req_rate   = '0;
        tick();
        tick();

        // Reset values.
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_duty", duty, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // 1: ch2 up to 3 at rate 0.
        done_seen = 0;
        send_cmd(2, 3, 0);
        check("t1_busy", 32'(busy), 32'h4);
        check("t1_duty_hold", duty, 32'd0);
        run_frame();
        check("t1_f1", 32'(duty_of(2)), 32'd1);
        run_frame();
        check("t1_f2", 32'(duty_of(2)), 32'd2);
        check("t1_done_early", 32'(done_seen), 32'd0);
        run_frame();
        check("t1_f3_vec", duty, 32'h0003_0000);
        check("t1_done_cnt", 32'(done_seen), 32'd1);
        check("t1_done_ch", 32'(last_done_ch), 32'd2);
        check("t1_done_pos", 32'(last_done_pos), 32'd2);
        check("t1_busy_clr", 32'(busy), 32'd0);

        // 2: ch0 to 10, then down to 7 with rate 2.
        send_cmd(0, 10, 0);
        run_frames(10);
        check("t2_setup", 32'(duty_of(0)), 32'd10);
        done_seen = 0;
        send_cmd(0, 7, 2);
        run_frame();
        check("t2_f1", 32'(duty_of(0)), 32'd10);
        run_frames(2);
        check("t2_f3", 32'(duty_of(0)), 32'd9);
        run_frames(3);
        check("t2_f6", 32'(duty_of(0)), 32'd8);
        run_frames(3);
        check("t2_f9", 32'(duty_of(0)), 32'd7);
        check("t2_busy", 32'(busy), 32'd0);
        run_frames(4);
        check("t2_no_underflow", 32'(duty_of(0)), 32'd7);
        check("t2_done_cnt", 32'(done_seen), 32'd1);

        // 3: ch1 toward 200, retarget to 40 after 50 steps.
        done_seen = 0;
        send_cmd(1, 200, 0);
        run_frames(50);
        check("t3_f50", 32'(duty_of(1)), 32'd50);
        check("t3_busy", 32'(busy), 32'h2);
        check("t3_no_done", 32'(done_seen), 32'd0);
        send_cmd(1, 40, 0);
        check("t3_no_jump", 32'(duty_of(1)), 32'd50);
        run_frame();
        check("t3_down", 32'(duty_of(1)), 32'd49);
        run_frames(9);
        check("t3_final", 32'(duty_of(1)), 32'd40);
        check("t3_done_cnt", 32'(done_seen), 32'd1);
        check("t3_done_ch", 32'(last_done_ch), 32'd1);
        check("t3_busy_clr", 32'(busy), 32'd0);

        // 4: command held through a walk.
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        req_valid  = 1'b1;
        req_ch     = 2'd3;
        req_target = 8'd5;
        req_rate   = 4'd0;
        #1;
        lows = 0;
        while (!req_ready && lows < 20) begin
            lows++;
            tick();
        end
        check("t4_ready_low", 32'(lows), 32'd4);
        tick();
        req_valid = 1'b0;
        check("t4_accepted", 32'(busy), 32'h8);
        run_frames(5);
        check("t4_duty", 32'(duty_of(3)), 32'd5);
        check("t4_busy_clr", 32'(busy), 32'd0);

        // 5: target equals current duty.
        done_seen = 0;
        send_cmd(2, 3, 0);
        check("t5_busy", 32'(busy), 32'd0);
        run_frames(3);
        check("t5_no_done", 32'(done_seen), 32'd0);
        check("t5_duty", 32'(duty_of(2)), 32'd3);

        // 6: reset during walk cycle 1.
        send_cmd(0, 20, 0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        check("t6_pre", 32'(duty_of(0)), 32'd8);
        rst = 1'b1;
        tick();
        check("t6_duty", duty, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        done_seen = 0;
        run_frame();
        check("t6_idle_after", duty, 32'd0);
        check("t6_no_done", 32'(done_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
